dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter N, default 64, data/address width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6, log2 of the number of N-bit words stored.
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra busy cycles per access (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port DM_addr  input  N  byte address from the datapath.
REQ-007 SHALL have port DM_writeData  input  N  store data.
REQ-008 SHALL have port DM_writeEnable  input  1  store request.
REQ-009 SHALL have port DM_readEnable  input  1  load request.
REQ-010 SHALL have port DM_readData  output  N  registered load data.
REQ-011 SHALL have port DM_ready  output  1  one-cycle access-complete strobe.
REQ-012 SHALL have port DM_error  output  1  misaligned-access flag, valid only while DM_ready=1.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and ACK.
REQ-014 SHALL, in IDLE with DM_writeEnable or DM_readEnable high at a rising edge, latch address, write data and operation type, then go to WAIT if WAIT_STATES>0, else to ACK.
REQ-015 SHALL, on entering WAIT, load a wait counter with WAIT_STATES-1, decrement it each cycle and go to ACK after the cycle in which it reads 0.
REQ-016 SHALL hold DM_ready=1 for exactly one cycle, the ACK cycle; the next state is always IDLE.
REQ-017 SHALL give a latency of WAIT_STATES+1 cycles from the request-sampling edge to the DM_ready cycle.
REQ-018 SHALL form the word index as latched address bits [DEPTH_LOG2+2:3]; higher address bits are ignored, so addresses wrap modulo 8*2^DEPTH_LOG2 bytes.
REQ-019 SHALL, for a read, load DM_readData from the latched index on the edge entering ACK, and hold DM_readData at all other times.
REQ-020 SHALL, for a write, update the word at the edge leaving ACK; DM_readData is unchanged for a write.
REQ-021 SHALL treat both enables high as a write only.
REQ-022 SHALL ignore changes on the request inputs while in WAIT or ACK, because the values are latched.
REQ-023 SHALL start a new access if the request is still high in the IDLE cycle after ACK, allowing back-to-back transfers with one idle cycle between them.

Reset
REQ-024 SHALL, with reset high at a rising edge, go to IDLE, clear the wait counter, set DM_readData=0, DM_ready=0 and DM_error=0, and clear every memory word to 0.
REQ-025 SHALL abort any access in progress on reset, including one in ACK; its write is discarded and no DM_ready pulse follows.
REQ-026 SHALL give reset priority over any request sampled at the same edge.

Configuration
REQ-027 SHALL support macro DMEM_ERR_EN for misaligned-access checking.
REQ-028 SHALL, with DMEM_ERR_EN defined and latched address bits [2:0] non-zero, assert DM_error=1 in the ACK cycle, suppress the write, and load DM_readData=0 for a read.
REQ-029 SHALL, without DMEM_ERR_EN, tie DM_error to 0, ignore address bits [2:0], and perform all accesses normally.

Verification (N=64, DEPTH_LOG2=6, WAIT_STATES=2 unless stated)
REQ-030 SHALL cover: reset, then read 0x10 -> DM_ready high exactly 3 cycles after the sampling edge, DM_readData=0.
REQ-031 SHALL cover: write 0x00000000DEADBEEF to 0x18, then read 0x18 -> DM_readData=0x00000000DEADBEEF; DM_ready pulses once per access.
REQ-032 SHALL cover: both enables high, addr 0x20, data 5; then read 0x20 -> 5; DM_readData unchanged during the write's ACK.
REQ-033 SHALL cover: write 0xAA to 0x208, then read 0x008 -> 0xAA (wrap-around).
REQ-034 SHALL cover: write 7 to 0x30, reset asserted in WAIT -> no DM_ready pulse; a later read of 0x30 -> 0.
REQ-035 SHALL cover, with DMEM_ERR_EN defined: write 9 to 0x1C -> DM_error=1 in ACK; read 0x18 -> 0 with DM_error=0; with WAIT_STATES=0, read 0x0 -> DM_ready in the cycle after sampling.

Source files
------------

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: IDLE -> WAIT -> ACK handshake over a word array.
// Define DMEM_ERR_EN to flag and suppress misaligned accesses.
module dmem_responder #(
  parameter int N           = 64,
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_ready,
  output logic         DM_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WLOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state, state_nx;

  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [N-1:0]          wdata_q;
  logic                  we_q;
  logic                  err_q;
  logic [N-1:0]          mem [DEPTH];

  logic                  req;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_err;
  logic                  rd_load;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_err;
  logic                  unused_addr;

  assign req     = DM_writeEnable | DM_readEnable;
  assign req_idx = DM_addr[DEPTH_LOG2+2:3];

`ifdef DMEM_ERR_EN
  assign req_err = |DM_addr[2:0];
`else
  assign req_err = 1'b0;
`endif

  assign unused_addr = ^{DM_addr[N-1:DEPTH_LOG2+3], DM_addr[2:0]};

  always_comb begin
    state_nx = state;
    rd_load  = 1'b0;
    rd_idx   = idx_q;
    rd_err   = err_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = (WAIT_STATES > 0) ? WAIT : ACK;
          rd_load  = !DM_writeEnable && (WAIT_STATES == 0);
          rd_idx   = req_idx;
          rd_err   = req_err;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = ACK;
          rd_load  = !we_q;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      DM_readData <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt     <= WLOAD;
        idx_q   <= req_idx;
        wdata_q <= DM_writeData;
        we_q    <= DM_writeEnable;
        err_q   <= req_err;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_load)
        DM_readData <= rd_err ? '0 : mem[rd_idx];
    end
  end

  // Stores commit only as ACK retires, so a reset in ACK drops them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ACK && we_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign DM_ready = (state == ACK);
  assign DM_error = DM_ready & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, hand sequences,
// and random traffic against an array-based memory model.
module tb_dmem_responder;
  localparam int N  = 64;
  localparam int DL = 6;
  localparam int W  = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] addr, wdata, rdata;
  logic         we, re, ready, err;
  logic [N-1:0] addr0, wdata0, rdata0;
  logic         we0, re0, ready0, err0;

  dmem_responder #(.N(N), .DEPTH_LOG2(DL), .WAIT_STATES(W)) dut (
    .clk(clk), .reset(reset),
    .DM_addr(addr), .DM_writeData(wdata),
    .DM_writeEnable(we), .DM_readEnable(re),
    .DM_readData(rdata), .DM_ready(ready), .DM_error(err)
  );

  dmem_responder #(.N(N), .DEPTH_LOG2(DL), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .DM_addr(addr0), .DM_writeData(wdata0),
    .DM_writeEnable(we0), .DM_readEnable(re0),
    .DM_readData(rdata0), .DM_ready(ready0), .DM_error(err0)
  );

  int tests = 0;
  int fails = 0;
  logic [N-1:0] model [64];
  logic [N-1:0] model_rd;

  typedef struct {
    bit           w;
    bit           r;
    logic [N-1:0] a;
    logic [N-1:0] d;
    logic [N-1:0] exp;
  } vec_t;
  vec_t tbl [7];

  function automatic int widx(input logic [N-1:0] a);
    return int'((a / 8) % 64);
  endfunction

  function automatic bit mis(input logic [N-1:0] a);
    return ERR_EN && ((a % 8) != 0);
  endfunction

  task automatic check(input string nm, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = '0;
    model_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic access(input bit w, input bit r, input logic [N-1:0] a,
                        input logic [N-1:0] d, output logic [N-1:0] got);
    logic [N-1:0] exp_rd;
    bit e;
    int lat;
    e = mis(a);
    if (w) exp_rd = model_rd;
    else   exp_rd = e ? '0 : model[widx(a)];
    @(negedge clk);
    addr = a; wdata = d; we = w; re = r;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
    addr = {$urandom, $urandom};
    wdata = {$urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 40);
    check("latency", N'(lat), N'(W + 1));
    check("rdata", rdata, exp_rd);
    check("error", N'(err), N'(e));
    got = rdata;
    @(negedge clk);
    check("ready_once", N'(ready), '0);
    if (w && !e) model[widx(a)] = d;
    model_rd = exp_rd;
  endtask

  task automatic quiet(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check(nm, N'(seen), '0);
  endtask

  initial begin
    logic [N-1:0] got;
    int gap;
    bit w, r;
    logic [N-1:0] a;

    reset = 1'b1;
    addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    addr0 = '0; wdata0 = '0; we0 = 1'b0; re0 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", N'(ready), '0);
    check("rst_rdata", rdata, '0);
    check("rst_error", N'(err), '0);
    check("rst_rdata0", rdata0, '0);
    reset = 1'b0;

    // zero-wait-state instance: ready in the cycle after sampling
    @(negedge clk);
    addr0 = 64'h0; re0 = 1'b1;
    @(posedge clk); #1 re0 = 1'b0;
    @(negedge clk);
    check("w0_rd_ready", N'(ready0), 64'd1);
    check("w0_rd_data", rdata0, '0);
    @(negedge clk);
    check("w0_ready_once", N'(ready0), '0);
    addr0 = 64'h40; wdata0 = 64'h123; we0 = 1'b1;
    @(posedge clk); #1 we0 = 1'b0;
    @(negedge clk);
    check("w0_wr_ready", N'(ready0), 64'd1);
    @(negedge clk);
    addr0 = 64'h40; re0 = 1'b1;
    @(posedge clk); #1 re0 = 1'b0;
    @(negedge clk);
    check("w0_rd2_ready", N'(ready0), 64'd1);
    check("w0_rd2_data", rdata0, 64'h123);

    tbl[0] = '{0, 1, 64'h10,  64'h0,        64'h0};
    tbl[1] = '{1, 0, 64'h18,  64'hDEADBEEF, 64'h0};
    tbl[2] = '{0, 1, 64'h18,  64'h0,        64'hDEADBEEF};
    tbl[3] = '{1, 1, 64'h20,  64'h5,        64'hDEADBEEF};
    tbl[4] = '{0, 1, 64'h20,  64'h0,        64'h5};
    tbl[5] = '{1, 0, 64'h208, 64'hAA,       64'h5};
    tbl[6] = '{0, 1, 64'h008, 64'h0,        64'hAA};
    for (int i = 0; i < 7; i++) begin
      access(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, got);
      check($sformatf("tbl%0d", i), got, tbl[i].exp);
    end

    // held request: ACK, one idle cycle, then a fresh full access
    @(negedge clk);
    addr = 64'h20; re = 1'b1;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!ready && gap < 40);
    check("b2b_first", rdata, 64'h5);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!ready && gap < 40);
    re = 1'b0;
    check("b2b_gap", N'(gap), N'(W + 2));
    check("b2b_second", rdata, 64'h5);
    quiet("b2b_stop", 6);

    // reset while in WAIT
    @(negedge clk);
    addr = 64'h30; wdata = 64'h7; we = 1'b1;
    @(posedge clk); #1 we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rstw_rdata", rdata, '0);
    quiet("rstw_noready", 6);
    access(0, 1, 64'h30, 64'h0, got);
    check("rstw_read30", got, '0);

    // reset while in ACK drops the store
    @(negedge clk);
    addr = 64'h38; wdata = 64'h55; we = 1'b1;
    @(posedge clk); #1 we = 1'b0;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!ready && gap < 40);
    check("rsta_reached", N'(ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    quiet("rsta_noready", 6);
    access(0, 1, 64'h38, 64'h0, got);
    check("rsta_read38", got, '0);

    if (ERR_EN) begin
      do_reset();
      access(1, 0, 64'h1C, 64'h9, got);
      access(0, 1, 64'h18, 64'h0, got);
      check("err_read18", got, '0);
      access(0, 1, 64'h1C, 64'h0, got);
    end

    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom % 2);
      r = w ? 1'($urandom % 2) : 1'b1;
      a = 64'($urandom_range(0, 4095));
      if ($urandom % 4 != 0) a = a & ~64'h7;
      access(w, r, a, {$urandom, $urandom}, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
